// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache/main-memory arbiter.
// Contents: arbiter FSM state enum, fill owner enum, burst geometry
// constants and the burst word-address helper.
package cache_mem_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int BURST_LEN   = 8;
  localparam int MEM_LATENCY = 4;
  localparam int WORD_IDX_W  = 3;
  // Block base = addr[15:4]: word index (3 bits) plus byte-in-word bit below it.
  localparam int BASE_W      = ADDR_W - WORD_IDX_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_IC_FILL = 2'd2,
    ST_DC_FILL = 2'd3
  } arb_state_t;

  typedef enum logic {
    FILL_IC = 1'b0,
    FILL_DC = 1'b1
  } fill_owner_t;

  function automatic logic [ADDR_W-1:0] burst_word_addr(
    input logic [BASE_W-1:0]     base,
    input logic [WORD_IDX_W-1:0] idx
  );
    return {base, idx, 1'b0};
  endfunction

endpackage

// File: rtl/mem_burst_gen.sv
// Burst address generator and return counter for one cache block fill.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           grant pulse: latch block base, clear counters
//   start_base      block base address (addr[15:4]) of the granted fill
//   fill_active     arbiter is in a fill state
//   ret_valid       read data returned to the owning cache this cycle
//   issue_active    a burst read is issued this cycle
//   issue_addr      word address of the read being issued
//   burst_done      the last word of the block is returning this cycle
module mem_burst_gen
  import cache_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BASE_W-1:0] start_base,
  input  logic              fill_active,
  input  logic              ret_valid,
  output logic              issue_active,
  output logic [ADDR_W-1:0] issue_addr,
  output logic              burst_done
);

  logic [BASE_W-1:0]     base_q;
  logic [WORD_IDX_W-1:0] issue_idx_q, issue_idx_d;
  logic                  issue_done_q, issue_done_d;
  logic [WORD_IDX_W-1:0] ret_cnt_q, ret_cnt_d;

  localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(BURST_LEN - 1);

  // Base is pure data: captured on grant, never reset.
  always_ff @(posedge clk) begin
    if (start) begin
      base_q <= start_base;
    end
  end

  always_comb begin
    issue_idx_d  = issue_idx_q;
    issue_done_d = issue_done_q;
    ret_cnt_d    = ret_cnt_q;
    if (start) begin
      issue_idx_d  = '0;
      issue_done_d = 1'b0;
      ret_cnt_d    = '0;
    end else if (fill_active) begin
      if (issue_active) begin
        // Index saturates on the last word; issue_done stops further reads.
        if (issue_idx_q == LAST_IDX) begin
          issue_done_d = 1'b1;
        end else begin
          issue_idx_d = issue_idx_q + 1'b1;
        end
      end
      if (ret_valid) begin
        ret_cnt_d = ret_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_idx_q  <= '0;
      issue_done_q <= 1'b0;
      ret_cnt_q    <= '0;
    end else begin
      issue_idx_q  <= issue_idx_d;
      issue_done_q <= issue_done_d;
      ret_cnt_q    <= ret_cnt_d;
    end
  end

  assign issue_active = fill_active & ~issue_done_q;
  assign issue_addr   = burst_word_addr(base_q, issue_idx_q);
  assign burst_done   = ret_valid & (ret_cnt_q == LAST_IDX);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter between the I-cache / D-cache fill FSMs and a single pipelined
// main memory. Grants block fills (8-word read bursts) and D-cache
// write-through stores, and routes returning read data to the fill owner.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ic_read_req, ic_addr             I-cache fill request / miss address
//   ic_mem_data, ic_mem_valid        fill data to I-cache
//   ic_wait                          I-cache request pending, not granted
//   dc_read_req, dc_addr             D-cache fill request / miss or store address
//   dc_write_req, dc_wdata           D-cache write-through store
//   dc_mem_data, dc_mem_valid        fill data to D-cache
//   dc_write_done                    one-cycle pulse: store issued
//   dc_wait                          D-cache request pending
//   mem_enable, mem_wr, mem_addr,
//   mem_wdata                        memory command
//   mem_rdata, mem_rdata_valid       memory read return
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined: fixed priority dc_write_req > dc_read_req > ic_read_req
//   defined:   write highest; simultaneous fill requests alternate owners
module cache_mem_arbiter
  import cache_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_mem_data,
  output logic              ic_mem_valid,
  output logic              ic_wait,
  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_write_req,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_mem_data,
  output logic              dc_mem_valid,
  output logic              dc_write_done,
  output logic              dc_wait,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid
);

  arb_state_t        state_q, state_d;
  logic              start;
  logic [BASE_W-1:0] start_base;
  logic              fill_active;
  logic              issue_active;
  logic [ADDR_W-1:0] issue_addr;
  logic              burst_done;
  logic              unused_addr_bits;

  // Byte-in-block bits of the fill address and the store byte bit are not used.
  assign unused_addr_bits = ^{ic_addr[3:0], dc_addr[0]};

`ifdef ARB_ROUND_ROBIN_EN
  fill_owner_t last_fill_q;

  // Reset behaves as if the D-cache had the previous fill, so the first
  // contested grant after reset goes to the I-cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_fill_q <= FILL_DC;
    end else if (start) begin
      last_fill_q <= (state_d == ST_IC_FILL) ? FILL_IC : FILL_DC;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dc_write_req) begin
          state_d = ST_WRITE;
        end else if (dc_read_req && ic_read_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = (last_fill_q == FILL_DC) ? ST_IC_FILL : ST_DC_FILL;
`else
          state_d = ST_DC_FILL;
`endif
        end else if (dc_read_req) begin
          state_d = ST_DC_FILL;
        end else if (ic_read_req) begin
          state_d = ST_IC_FILL;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_IC_FILL, ST_DC_FILL: begin
        if (burst_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign start       = (state_q == ST_IDLE) &&
                       ((state_d == ST_IC_FILL) || (state_d == ST_DC_FILL));
  assign start_base  = (state_d == ST_IC_FILL) ? ic_addr[ADDR_W-1:4] : dc_addr[ADDR_W-1:4];
  assign fill_active = (state_q == ST_IC_FILL) || (state_q == ST_DC_FILL);

  mem_burst_gen u_burst (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_base   (start_base),
    .fill_active  (fill_active),
    .ret_valid    (ic_mem_valid | dc_mem_valid),
    .issue_active (issue_active),
    .issue_addr   (issue_addr),
    .burst_done   (burst_done)
  );

  always_comb begin
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    dc_write_done = 1'b0;
    case (state_q)
      ST_WRITE: begin
        mem_enable    = 1'b1;
        mem_wr        = 1'b1;
        mem_addr      = {dc_addr[ADDR_W-1:1], 1'b0};
        mem_wdata     = dc_wdata;
        dc_write_done = 1'b1;
      end
      ST_IC_FILL, ST_DC_FILL: begin
        if (issue_active) begin
          mem_enable = 1'b1;
          mem_addr   = issue_addr;
        end
      end
      default: ;
    endcase
  end

  // Returns outside a fill (IDLE/WRITE, stale after reset) are dropped.
  assign ic_mem_valid = mem_rdata_valid & (state_q == ST_IC_FILL);
  assign dc_mem_valid = mem_rdata_valid & (state_q == ST_DC_FILL);
  assign ic_mem_data  = mem_rdata;
  assign dc_mem_data  = mem_rdata;

  assign ic_wait = ic_read_req & (state_q != ST_IC_FILL);
  assign dc_wait = (dc_read_req & (state_q != ST_DC_FILL)) | (dc_write_req & ~dc_write_done);

endmodule
